// File: rtl/mode_key_ctrl.sv
// rtl/mode_key_ctrl.sv - front-panel key sequencer: mode select, step pulses, auto-repeat, idle timeout
module mode_key_ctrl #(
  parameter int MODE_COUNT    = 4,
  parameter int HOME_MODE     = 1,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int TIMEOUT       = 30000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_RIGHT,
  input  logic       BTN_LEFT,
  output logic [3:0] MODE,
  output logic [3:0] NUM_SYNC,
  output logic       MODE_CHG
);

  // Key vector order doubles as priority order: bit 0 wins.
  localparam int KEY_MODE  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_LEFT  = 4;

  localparam logic [3:0]  HOME      = 4'(HOME_MODE);
  localparam logic [3:0]  LAST      = 4'(MODE_COUNT - 1);
  localparam logic [15:0] DELAY_C   = 16'(REPEAT_DELAY);
  localparam logic [15:0] PERIOD_C  = 16'(REPEAT_PERIOD);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  keys;
  logic [4:0]  prev_q;
  logic [4:0]  rise;
  // Owner is kept one-hot in key order; bits [4:1] line up with NUM_SYNC.
  logic [4:0]  owner_q, owner_d;
  logic        owner_level;
  logic [15:0] rpt_cnt_q, rpt_cnt_d, rpt_inc, rpt_target;
  logic [15:0] idle_cnt_q, idle_cnt_d, idle_inc;
  logic [3:0]  mode_d;
  logic [3:0]  num_sync_d;
  logic        mode_chg_d;

  assign keys        = {BTN_LEFT, BTN_RIGHT, BTN_DOWN, BTN_UP, BTN_MODE};
  assign rise        = keys & ~prev_q;
  assign owner_level = |(keys & owner_q);
  assign rpt_inc     = (rpt_cnt_q == 16'hFFFF) ? rpt_cnt_q : rpt_cnt_q + 16'd1;
  assign idle_inc    = (idle_cnt_q == 16'hFFFF) ? idle_cnt_q : idle_cnt_q + 16'd1;
  assign rpt_target  = (state_q == DELAY) ? DELAY_C : PERIOD_C;

  // Next-state, counters and output pulses for the key ownership machine.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rpt_cnt_d  = rpt_cnt_q;
    idle_cnt_d = idle_cnt_q;
    mode_d     = MODE;
    num_sync_d = 4'b0000;
    mode_chg_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise[KEY_MODE]) begin
          owner_d    = 5'b00001;
          mode_d     = (MODE == LAST) ? 4'd0 : MODE + 4'd1;
          mode_chg_d = 1'b1;
          state_d    = HELD;
        end else if (rise[KEY_UP]) begin
          owner_d    = 5'b00010;
          num_sync_d = 4'b0001;
          rpt_cnt_d  = 16'd0;
          state_d    = DELAY;
        end else if (rise[KEY_DOWN]) begin
          owner_d    = 5'b00100;
          num_sync_d = 4'b0010;
          rpt_cnt_d  = 16'd0;
          state_d    = DELAY;
        end else if (rise[KEY_RIGHT]) begin
          owner_d    = 5'b01000;
          num_sync_d = 4'b0100;
          state_d    = HELD;
        end else if (rise[KEY_LEFT]) begin
          owner_d    = 5'b10000;
          num_sync_d = 4'b1000;
          state_d    = HELD;
        end else if ((MODE != HOME) && TICK) begin
          if (idle_inc == TIMEOUT_C) begin
            mode_d     = HOME;
            mode_chg_d = 1'b1;
            idle_cnt_d = 16'd0;
          end else begin
            idle_cnt_d = idle_inc;
          end
        end
      end
      HELD: begin
        if (!owner_level) begin
          state_d = IDLE;
        end
      end
      DELAY, REPEAT: begin
        // Release is checked first so a same-cycle count match is dropped.
        if (!owner_level) begin
          state_d = IDLE;
        end else if (TICK) begin
          if (rpt_inc == rpt_target) begin
            num_sync_d = owner_q[4:1];
            rpt_cnt_d  = 16'd0;
            state_d    = REPEAT;
          end else begin
            rpt_cnt_d = rpt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) || (|rise) || (MODE == HOME)) begin
      idle_cnt_d = 16'd0;
    end
  end

  // State, counters, edge-detect history and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      owner_q    <= 5'b00000;
      prev_q     <= 5'b11111;
      rpt_cnt_q  <= 16'd0;
      idle_cnt_q <= 16'd0;
      MODE       <= HOME;
      NUM_SYNC   <= 4'b0000;
      MODE_CHG   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prev_q     <= keys;
      rpt_cnt_q  <= rpt_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      MODE       <= mode_d;
      NUM_SYNC   <= num_sync_d;
      MODE_CHG   <= mode_chg_d;
    end
  end

endmodule

// File: tb/tb_mode_key_ctrl.sv
// tb/tb_mode_key_ctrl.sv - scoreboard testbench for mode_key_ctrl
module tb_mode_key_ctrl;

  logic       CLK;
  logic       RESET;
  logic       TICK;
  logic       BTN_MODE;
  logic       BTN_UP;
  logic       BTN_DOWN;
  logic       BTN_RIGHT;
  logic       BTN_LEFT;
  logic [3:0] MODE;
  logic [3:0] NUM_SYNC;
  logic       MODE_CHG;

  typedef struct {
    logic [3:0] ns;
    logic       chg;
    logic [3:0] mode;
    int         tick;
  } pulse_t;

  typedef struct {
    logic [3:0] ns;
    logic       chg;
    logic [3:0] mode;
  } snap_t;

  pulse_t exp_q[$];
  snap_t  snap_q[$];
  string  snap_name_q[$];

  int checks   = 0;
  int errors   = 0;
  int tick_cnt = 0;
  int pulse_no = 0;
  bit done     = 1'b0;

  mode_key_ctrl #(
    .MODE_COUNT   (4),
    .HOME_MODE    (1),
    .REPEAT_DELAY (3),
    .REPEAT_PERIOD(2),
    .TIMEOUT      (5)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .TICK     (TICK),
    .BTN_MODE (BTN_MODE),
    .BTN_UP   (BTN_UP),
    .BTN_DOWN (BTN_DOWN),
    .BTN_RIGHT(BTN_RIGHT),
    .BTN_LEFT (BTN_LEFT),
    .MODE     (MODE),
    .NUM_SYNC (NUM_SYNC),
    .MODE_CHG (MODE_CHG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // TICK high on every 4th rising edge
  initial begin
    int ph;
    ph   = 0;
    TICK = 1'b0;
    forever begin
      @(negedge CLK);
      ph   = (ph + 1) % 4;
      TICK = (ph == 0);
    end
  end

  // running count of TICK edges, used as a timestamp for expected pulses
  always @(posedge CLK) begin
    if (TICK) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, required completion before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_pulse(input logic [3:0] ns, input logic chg, input logic [3:0] mode, input int tick);
    pulse_t p;
    p.ns   = ns;
    p.chg  = chg;
    p.mode = mode;
    p.tick = tick;
    exp_q.push_back(p);
  endtask

  task automatic expect_snap(input string name, input logic [3:0] mode);
    snap_t s;
    s.ns   = 4'b0000;
    s.chg  = 1'b0;
    s.mode = mode;
    snap_q.push_back(s);
    snap_name_q.push_back(name);
  endtask

  task automatic sync_tick();
    do @(posedge CLK); while (TICK !== 1'b1);
    @(negedge CLK);
  endtask

  task automatic wait_tick_cnt(input int target);
    while (tick_cnt < target) @(negedge CLK);
  endtask

  task automatic press_mode(input logic [3:0] new_mode, output int t);
    sync_tick();
    t = tick_cnt;
    expect_pulse(4'b0000, 1'b1, new_mode, t);
    BTN_MODE = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    BTN_MODE = 1'b0;
    @(negedge CLK);
  endtask

  // Monitor: state snapshots, scoreboard pops on every output pulse, summary
  initial begin
    pulse_t p;
    snap_t  s;
    string  nm;
    forever begin
      @(negedge CLK);
      while (snap_q.size() > 0) begin
        s  = snap_q.pop_front();
        nm = snap_name_q.pop_front();
        checks++;
        if (MODE !== s.mode || NUM_SYNC !== s.ns || MODE_CHG !== s.chg) begin
          errors++;
          $display("FAIL %s: got MODE=%0d NUM_SYNC=%b MODE_CHG=%b, required MODE=%0d NUM_SYNC=%b MODE_CHG=%b",
                   nm, MODE, NUM_SYNC, MODE_CHG, s.mode, s.ns, s.chg);
        end
      end
      if (!RESET && (MODE_CHG === 1'b1 || (|NUM_SYNC) === 1'b1)) begin
        checks++;
        pulse_no++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse%0d unexpected: got NUM_SYNC=%b MODE_CHG=%b MODE=%0d tick=%0d, required no output",
                   pulse_no, NUM_SYNC, MODE_CHG, MODE, tick_cnt);
        end else begin
          p = exp_q.pop_front();
          if (NUM_SYNC !== p.ns || MODE_CHG !== p.chg || MODE !== p.mode || tick_cnt != p.tick) begin
            errors++;
            $display("FAIL pulse%0d: got NUM_SYNC=%b MODE_CHG=%b MODE=%0d tick=%0d, required NUM_SYNC=%b MODE_CHG=%b MODE=%0d tick=%0d",
                     pulse_no, NUM_SYNC, MODE_CHG, MODE, tick_cnt, p.ns, p.chg, p.mode, p.tick);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending: got %0d expected outputs never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    int t;
    int t2;
    RESET     = 1'b1;
    BTN_MODE  = 1'b1;
    BTN_UP    = 1'b0;
    BTN_DOWN  = 1'b0;
    BTN_RIGHT = 1'b0;
    BTN_LEFT  = 1'b0;

    // 1: MODE held through reset release, then four presses wrap back to home
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    expect_snap("reset_state", 4'd1);
    repeat (4) @(negedge CLK);
    expect_snap("held_through_reset", 4'd1);
    @(negedge CLK);
    BTN_MODE = 1'b0;
    @(negedge CLK);
    press_mode(4'd2, t);
    press_mode(4'd3, t);
    press_mode(4'd0, t);
    press_mode(4'd1, t);

    // 2: UP held for 20 ticks: press pulse plus repeats at +3,+5,...,+19
    sync_tick();
    t = tick_cnt;
    expect_pulse(4'b0001, 1'b0, 4'd1, t);
    for (int k = 3; k <= 19; k += 2) expect_pulse(4'b0001, 1'b0, 4'd1, t + k);
    BTN_UP = 1'b1;
    wait_tick_cnt(t + 20);
    BTN_UP = 1'b0;
    wait_tick_cnt(t + 26);

    // 3: RIGHT held for 50 ticks gives a single pulse
    sync_tick();
    t = tick_cnt;
    expect_pulse(4'b0100, 1'b0, 4'd1, t);
    BTN_RIGHT = 1'b1;
    wait_tick_cnt(t + 50);
    BTN_RIGHT = 1'b0;
    repeat (4) @(negedge CLK);

    // 4: UP and DOWN together; DOWN left high after UP release stays silent
    sync_tick();
    t = tick_cnt;
    expect_pulse(4'b0001, 1'b0, 4'd1, t);
    BTN_UP   = 1'b1;
    BTN_DOWN = 1'b1;
    wait_tick_cnt(t + 2);
    BTN_UP = 1'b0;
    wait_tick_cnt(t + 6);
    BTN_DOWN = 1'b0;
    repeat (2) @(negedge CLK);
    sync_tick();
    t = tick_cnt;
    expect_pulse(4'b0010, 1'b0, 4'd1, t);
    BTN_DOWN = 1'b1;
    repeat (2) @(negedge CLK);
    BTN_DOWN = 1'b0;
    repeat (4) @(negedge CLK);

    // 5a: idle in mode 0 for 5 ticks returns to home
    press_mode(4'd2, t);
    press_mode(4'd3, t);
    press_mode(4'd0, t);
    expect_pulse(4'b0000, 1'b1, 4'd1, t + 5);
    wait_tick_cnt(t + 7);

    // 5b: a key at idle tick 4 restarts the timeout count
    press_mode(4'd2, t);
    press_mode(4'd3, t);
    press_mode(4'd0, t);
    wait_tick_cnt(t + 4);
    expect_pulse(4'b0100, 1'b0, 4'd0, t + 4);
    BTN_RIGHT = 1'b1;
    repeat (2) @(negedge CLK);
    BTN_RIGHT = 1'b0;
    expect_pulse(4'b0000, 1'b1, 4'd1, t + 9);
    wait_tick_cnt(t + 11);

    // 6: reset asserted mid-repeat aborts at once; held key never fires afterwards
    press_mode(4'd2, t);
    sync_tick();
    t = tick_cnt;
    expect_pulse(4'b0010, 1'b0, 4'd2, t);
    expect_pulse(4'b0010, 1'b0, 4'd2, t + 3);
    expect_pulse(4'b0010, 1'b0, 4'd2, t + 5);
    BTN_DOWN = 1'b1;
    wait_tick_cnt(t + 6);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    expect_snap("reset_mid_repeat", 4'd1);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    t2 = tick_cnt;
    wait_tick_cnt(t2 + 8);
    BTN_DOWN = 1'b0;
    repeat (4) @(negedge CLK);
    expect_snap("after_reset_release", 4'd1);
    repeat (4) @(negedge CLK);
    done = 1'b1;
  end

endmodule

// File: doc/mode_key_ctrl.md
# mode_key_ctrl

Front-panel key sequencer for the watch datapath. Turns five synchronized, debounced push-button levels into the `MODE` selector and single-cycle `NUM_SYNC` step pulses consumed by the mode blocks, such as the date-set block, which treats `MODE == 0` as set mode. Provides:
- exclusive key ownership, so only one action is active at a time;
- auto-repeat on held up/down keys;
- inactivity timeout back to the home display mode.

## Interface
Parameters:
- `MODE_COUNT`, 4: number of modes. `MODE` cycles `0..MODE_COUNT-1`, with `MODE_COUNT` in 2..16.
- `HOME_MODE`, 1: mode entered at reset and on timeout. Must be `< MODE_COUNT`.
- `REPEAT_DELAY`, 500: `TICK`s an up/down key must be held before the first repeat. Range 1..65535.
- `REPEAT_PERIOD`, 100: `TICK`s between subsequent repeats. Range 1..65535.
- `TIMEOUT`, 30000: idle `TICK`s outside `HOME_MODE` before forced return. Range 1..65535.

Ports:
- `CLK` in 1: system clock; all state updates on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `TICK` in 1: one-`CLK` time-base strobe (nominally 1 kHz).
- `BTN_MODE` in 1: level, high = pressed. Advances mode.
- `BTN_UP` in 1: level. Value increment.
- `BTN_DOWN` in 1: level. Value decrement.
- `BTN_RIGHT` in 1: level. Cursor +1.
- `BTN_LEFT` in 1: level. Cursor −1.
- `MODE` out 4: current mode, registered.
- `NUM_SYNC` out 4: one-hot step pulse, registered. bit0 = up, bit1 = down, bit2 = cursor+, bit3 = cursor−.
- `MODE_CHG` out 1: one-`CLK` pulse on every `MODE` change.

## Operation
Key edge detection:
- A previous-level register is kept per key.
- A *rise* is the key sampled high while its previous level was low.
- Previous-level registers reset to all ones, so a key held through reset release never fires.

Owner arbitration:
- In `IDLE`, the highest-priority rising key becomes the owner. Priority: `MODE` > `UP` > `DOWN` > `RIGHT` > `LEFT`.
- All other keys are ignored until the owner is released.
- Keys already high when the controller returns to `IDLE` do not fire; each needs a fresh rise.

State machine, with states `IDLE`, `HELD`, `DELAY`, `REPEAT`:
- **`IDLE`, rise of `MODE`**: `MODE` ← `MODE+1`, wrapping `MODE_COUNT-1` → 0. Pulse `MODE_CHG`. Go to `HELD`.
- **`IDLE`, rise of `RIGHT`/`LEFT`**: pulse `NUM_SYNC[2]`/`[3]`. Go to `HELD`.
- **`IDLE`, rise of `UP`/`DOWN`**: pulse `NUM_SYNC[0]`/`[1]`. Clear the repeat counter. Go to `DELAY`.
- **`HELD`**: owner low → `IDLE`. No pulses.
- **`DELAY`**: owner low → `IDLE`. Otherwise the counter increments on `TICK`. When an increment makes it equal to `REPEAT_DELAY`: pulse the owner's bit, clear the counter, go to `REPEAT`.
- **`REPEAT`**: owner low → `IDLE`. Otherwise the counter increments on `TICK`. When it reaches `REPEAT_PERIOD`: pulse, clear the counter, stay in `REPEAT`.
- Release takes precedence over a same-cycle count match: no pulse is issued.

Timeout:
- A 16-bit idle counter increments on `TICK` only while in `IDLE` with `MODE != HOME_MODE`.
- It clears on any rise, in any non-`IDLE` state, and when `MODE == HOME_MODE`.
- When it reaches `TIMEOUT`: `MODE` ← `HOME_MODE`, pulse `MODE_CHG`, clear the counter.
- A rise in the same cycle wins, and the counter clears.
- Pressing `MODE` so that it lands on `HOME_MODE` still pulses `MODE_CHG`.

Other rules:
- `NUM_SYNC` is emitted in every mode. Consumers gate on `MODE`.
- At most one bit of `NUM_SYNC` is ever high, and never in the same cycle as `MODE_CHG`.
- Counters are 16-bit and saturate; they cannot wrap given the parameter ranges.

## Timing
- Reset values: `MODE = HOME_MODE`, `NUM_SYNC = 0`, `MODE_CHG = 0`, state `IDLE`, all counters 0, previous-level registers all ones.
- Reset is asynchronous. Asserting it mid-hold or mid-repeat aborts immediately; no pulse is issued.
- Key latency: a rise sampled at edge n produces outputs high for exactly the `CLK` cycle after edge n.
- First repeat: `REPEAT_DELAY` `TICK`s after the initial pulse. Subsequent repeats: every `REPEAT_PERIOD` `TICK`s, each output one cycle after the matching `TICK` edge.
- Back-to-back: a release sampled at edge n returns to `IDLE` at n. A different key's rise at edge n+1 is served, giving a minimum gap of one cycle.

## Test plan
Bench parameters: `MODE_COUNT=4`, `HOME_MODE=1`, `REPEAT_DELAY=3`, `REPEAT_PERIOD=2`, `TIMEOUT=5`. `TICK` is asserted every 4th `CLK`.

1. **Reset and mode cycling.** Hold `BTN_MODE` high through reset release → no `MODE_CHG`, `MODE=1`. Release, then apply 4 presses → `MODE` = 2, 3, 0, 1, with one `MODE_CHG` per press.
2. **Auto-repeat.** Hold `BTN_UP` for 20 `TICK`s → `NUM_SYNC=0001` pulses at press, then at +3, +5, +7 … `TICK`s (10 pulses total). Release → no further pulses.
3. **Single-shot cursor.** Hold `BTN_RIGHT` for 50 `TICK`s → exactly one `NUM_SYNC=0100` pulse.
4. **Arbitration.** `UP` and `DOWN` rise on the same edge → only `0001` pulses. Release `UP` while `DOWN` stays high → no `0010` until `DOWN` is re-pressed.
5. **Timeout.** Set `MODE=0` and stay idle for 5 `TICK`s → `MODE=1` plus a `MODE_CHG` pulse. Pressing a key at `TICK` 4 restarts the count.
6. **Reset mid-repeat.** Hold `DOWN` in `REPEAT`, then assert `RESET` → `NUM_SYNC=0` and `MODE=1` immediately. No pulse after release while the key is still held.
